// File: rtl/gcb_pkg.sv
// Shared types, constants and helpers for the gated capture bank.
// The optional capture counters are controlled by the CAPTURE_CNT_EN macro.
package gcb_pkg;

  typedef enum logic {
    LEVEL = 1'b0,
    EDGE  = 1'b1
  } gcb_mode_e;

  localparam int GCB_CNT_W = 8;

  // Counts up by one but sticks at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_val);
    return (value >= max_val) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/gcb_channel.sv
// One enable-gated capture channel: data register, sticky update flag, optional
// edge detector and, when CAPTURE_CNT_EN is defined, a saturating capture counter.
module gcb_channel
  import gcb_pkg::*;
#(
  parameter int        WIDTH = 4,
  parameter gcb_mode_e MODE  = LEVEL,
  parameter int        CNT_W = GCB_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_upd,
  output logic [CNT_W-1:0] o_cnt
);

  logic             w_cap;
  logic [WIDTH-1:0] r_data;
  logic             r_upd;

  // In edge mode only a low-to-high step of the enable captures.
  if (MODE == EDGE) begin : g_edge
    logic r_en_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_en_d <= 1'b0;
      else       r_en_d <= i_en;
    end

    assign w_cap = i_en & ~r_en_d;
  end else begin : g_level
    assign w_cap = i_en;
  end

  // A capture at the same edge as a read keeps the flag set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data <= '0;
      r_upd  <= 1'b0;
    end else begin
      if (w_cap) r_data <= i_din;
      if (w_cap)     r_upd <= 1'b1;
      else if (i_rd) r_upd <= 1'b0;
    end
  end

  assign o_dout = r_data;
  assign o_upd  = r_upd;

`ifdef CAPTURE_CNT_EN
  localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

  logic [CNT_W-1:0] r_cnt;

  // A read clears the count; a coinciding capture restarts it at one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_rd) begin
      r_cnt <= w_cap ? CNT_W'(1) : '0;
    end else if (w_cap) begin
      r_cnt <= CNT_W'(sat_inc(32'(r_cnt), CNT_MAX));
    end
  end

  assign o_cnt = r_cnt;
`else
  assign o_cnt = '0;
`endif

endmodule

// File: rtl/gated_capture_bank.sv
// Bank of CH enable-gated capture channels with a registered read port.
// Define CAPTURE_CNT_EN to build per-channel capture counters behind o_rd_cnt.
module gated_capture_bank
  import gcb_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CH        = 2,
  parameter int EDGE_MODE = 0,
  parameter int CNT_W     = GCB_CNT_W
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [CH-1:0]                       i_en,
  input  logic [CH*WIDTH-1:0]                 i_din,
  output logic [CH*WIDTH-1:0]                 o_dout,
  output logic [CH-1:0]                       o_upd,
  input  logic                                i_rd_req,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] i_rd_sel,
  output logic [WIDTH-1:0]                    o_rd_data,
  output logic                                o_rd_vld,
  output logic [CNT_W-1:0]                    o_rd_cnt
);

  localparam gcb_mode_e MODE = (EDGE_MODE != 0) ? EDGE : LEVEL;

  logic [CH-1:0]    w_rd_ch;
  logic [WIDTH-1:0] w_dout_ch [CH];
  logic [CNT_W-1:0] w_cnt_ch  [CH];
  logic [WIDTH-1:0] w_sel_data;
  logic [CNT_W-1:0] w_sel_cnt;

  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_vld;
  logic [CNT_W-1:0] r_rd_cnt;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    gcb_channel #(
      .WIDTH (WIDTH),
      .MODE  (MODE),
      .CNT_W (CNT_W)
    ) u_ch (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (i_en[g]),
      .i_din  (i_din[g*WIDTH +: WIDTH]),
      .i_rd   (w_rd_ch[g]),
      .o_dout (w_dout_ch[g]),
      .o_upd  (o_upd[g]),
      .o_cnt  (w_cnt_ch[g])
    );

    assign o_dout[g*WIDTH +: WIDTH] = w_dout_ch[g];
  end

  // An out-of-range select matches no channel, so it reads zeros and touches nothing.
  always_comb begin
    w_rd_ch    = '0;
    w_sel_data = '0;
    w_sel_cnt  = '0;
    for (int i = 0; i < CH; i++) begin
      if (int'(i_rd_sel) == i) begin
        w_rd_ch[i] = i_rd_req;
        w_sel_data = w_dout_ch[i];
        w_sel_cnt  = w_cnt_ch[i];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_data <= '0;
      r_rd_vld  <= 1'b0;
      r_rd_cnt  <= '0;
    end else begin
      r_rd_vld <= i_rd_req;
      if (i_rd_req) begin
        r_rd_data <= w_sel_data;
        r_rd_cnt  <= w_sel_cnt;
      end
    end
  end

  assign o_rd_data = r_rd_data;
  assign o_rd_vld  = r_rd_vld;
  assign o_rd_cnt  = r_rd_cnt;

endmodule

// File: doc/gated_capture_bank.md
# gated_capture_bank

Parametrised bank of CH enable-gated capture registers. On each rising clock edge, every channel whose enable qualifies loads its input word; otherwise it holds. The block generalises the single-channel conditional-copy helper into a synthesizable unit with configurable width and channel count, level- or edge-qualified enables, sticky update flags, a registered read port, and optional per-channel capture counters. It sits between free-running counter sources and downstream consumers that sample values on demand.

## Interface
- WIDTH, 4, data bits per channel (≥1)
- CH, 2, channel count (≥1)
- EDGE_MODE, 0, 0 = capture while en high (level); 1 = capture only on a 0→1 transition of en
- CNT_W, 8, capture-counter width (used only with CAPTURE_CNT_EN)
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- en  in  CH  per-channel capture enable
- din  in  CH*WIDTH  channel i in bits [i*WIDTH +: WIDTH]
- dout  out  CH*WIDTH  current captured value per channel
- upd  out  CH  sticky flag: channel captured since last read
- rd_req  in  1  read strobe, sampled at the clock edge
- rd_sel  in  max(1,$clog2(CH))  channel to read
- rd_data  out  WIDTH  registered read data
- rd_vld  out  1  one-cycle pulse qualifying rd_data
- rd_cnt  out  CNT_W  capture count of the channel being read

## Operation
- Capture condition for channel i (cap[i]):
  - EDGE_MODE=0: en[i].
  - EDGE_MODE=1: en[i] & ~en_d[i], where en_d is en registered per channel.
- When cap[i] is true: dout[i] ← din[i], and upd[i] ← 1. Otherwise dout[i] and upd[i] hold.
- Read, when rd_req=1 and rd_sel<CH:
  - rd_data ← dout[rd_sel]. This is the value before any capture at the same edge.
  - rd_vld ← 1.
  - upd[rd_sel] is cleared.
- Read, when rd_req=1 and rd_sel≥CH: rd_data ← 0 and rd_vld ← 1. No flag or counter changes.
- When rd_req=0: rd_vld ← 0 and rd_data holds.
- Read and capture on the same channel at the same edge: capture wins. upd stays 1; rd_data returns the old value.
- Different channels never interact.

## Timing
- Reset values, applied asynchronously: dout, upd, en_d, rd_data, rd_vld, rd_cnt and all counters = 0.
- Capture latency: din sampled at edge N is visible on dout after edge N, i.e. 1 cycle.
- Read latency: rd_req sampled at edge N gives rd_data/rd_vld valid after edge N, for exactly one cycle per request.
- Back-to-back reads are allowed on every cycle.
- Edge mode after reset: en_d=0, so en already high at the first edge after reset release counts as a rise.
- Reset asserted mid-operation clears all state immediately. Any pending read is lost; rd_vld drops with no clock.
- No combinational path from inputs to outputs.

## Configuration
- Macro CAPTURE_CNT_EN enables per-channel capture counters.
- Defined:
  - Each channel has a CNT_W-bit counter that increments on cap[i] and saturates at 2^CNT_W−1.
  - A valid read registers the count onto rd_cnt and clears the counter.
  - If a capture coincides with the read, the counter becomes 1.
  - An out-of-range read gives rd_cnt=0.
- Undefined: no counters are built; rd_cnt is tied to 0. The port is always present.

## Structure
- Package gcb_pkg contains:
  - typedef for the mode (LEVEL, EDGE)
  - default CNT_W constant
  - saturating-increment function
- Sub-module gcb_channel, one instance per channel. Each instance holds:
  - data register
  - en_d
  - upd
  - counter under the macro
- The top level holds the generate loop and the read mux/registers.

## Test plan
- Reset: assert rst mid-run with captures active → all outputs 0 immediately, without a clock edge. Release → first capture follows normally.
- Level mode, CH=2, WIDTH=4: en=2'b01 and din0=2 for 3 edges → dout0=2 after first edge, upd=2'b01, dout1=0. With macro: read ch0 → rd_cnt=3.
- Edge mode: en0 held high for 3 edges while din0 = 5, 6, 7 → dout0=5 only. Count=1. Drop en0 then raise it with din0=9 → dout0=9.
- Read collision: rd_req with rd_sel=0 at the same edge as a capture of din0=7 over old 3 → rd_data=3, rd_vld=1 for one cycle, upd0 stays 1, dout0=7. With macro: rd_cnt shows the old count, counter=1.
- Out of range, CH=3: rd_sel=3 → rd_data=0, rd_vld=1, rd_cnt=0, no upd change.
- Saturation, CNT_W=4, macro defined: 20 level-mode captures, then read → rd_cnt=15. Immediate second read → rd_cnt=0, upd=0.
